// File: rtl/gelato_fetch_scheduler.sv
// gelato_fetch_scheduler: round-robin warp fetch scheduler feeding I-Fetch one ready warp at a time
module gelato_fetch_scheduler #(
  parameter int NUM_WARPS       = 32,
  parameter int WARP_NUM_WIDTH  = 5,
  parameter int ADDR_WIDTH      = 32,
  parameter int SPLIT_NUM_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       launch_valid,
  input  logic [WARP_NUM_WIDTH-1:0]  launch_warp,
  input  logic [ADDR_WIDTH-1:0]      launch_pc,
  input  logic                       wb_valid,
  input  logic [WARP_NUM_WIDTH-1:0]  wb_warp,
  input  logic [ADDR_WIDTH-1:0]      wb_pc,
  input  logic [SPLIT_NUM_WIDTH-1:0] wb_split,
  input  logic                       wb_exit,
  output logic                       valid,
  output logic [ADDR_WIDTH-1:0]      pc,
  output logic [WARP_NUM_WIDTH-1:0]  warp_num,
  output logic [SPLIT_NUM_WIDTH-1:0] split_table_num,
  input  logic                       caught,
  output logic                       all_idle
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [NUM_WARPS-1:0] active, ready, active_n, ready_n, cand;
  logic [ADDR_WIDTH-1:0] pc_q [NUM_WARPS];
  logic [SPLIT_NUM_WIDTH-1:0] split_q [NUM_WARPS];
  logic [WARP_NUM_WIDTH-1:0] rr_ptr, rr_n, start, idx, pick_idx;
  logic pick_found, load, launch_ok, wb_ok, retire;
  assign valid = (state == OFFER);
  assign retire = (state == OFFER) && caught;
  assign launch_ok = launch_valid && !active[launch_warp];
  assign wb_ok = wb_valid && active[wb_warp] && !ready[wb_warp];
  always_comb begin
    cand = active & ready;
    start = retire ? warp_num + WARP_NUM_WIDTH'(1) : rr_ptr;
    if (retire) cand[warp_num] = 1'b0;
    pick_found = 1'b0;
    pick_idx = '0;
    idx = '0;
    // descending scan so the smallest offset from start wins
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      idx = start + WARP_NUM_WIDTH'(k);
      if (cand[idx]) begin
        pick_found = 1'b1;
        pick_idx = idx;
      end
    end
    load = (state == IDLE || caught) && pick_found;
    state_n = (state == IDLE || caught) ? (pick_found ? OFFER : IDLE) : state;
    rr_n = retire ? start : rr_ptr;
    active_n = active;
    ready_n = ready;
    if (retire) ready_n[warp_num] = 1'b0;
    if (launch_ok) begin
      active_n[launch_warp] = 1'b1;
      ready_n[launch_warp] = 1'b1;
    end
    if (wb_ok) begin
      active_n[wb_warp] = !wb_exit;
      ready_n[wb_warp] = !wb_exit;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      active <= '0;
      ready <= '0;
      rr_ptr <= '0;
      pc <= '0;
      warp_num <= '0;
      split_table_num <= '0;
      all_idle <= 1'b1;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i] <= '0;
        split_q[i] <= '0;
      end
    end else begin
      state <= state_n;
      active <= active_n;
      ready <= ready_n;
      rr_ptr <= rr_n;
      all_idle <= ~|active_n;
      if (load) begin
        pc <= pc_q[pick_idx];
        warp_num <= pick_idx;
        split_table_num <= split_q[pick_idx];
      end
      if (launch_ok) begin
        pc_q[launch_warp] <= launch_pc;
        split_q[launch_warp] <= '0;
      end
      if (wb_ok && !wb_exit) begin
        pc_q[wb_warp] <= wb_pc;
        split_q[wb_warp] <= wb_split;
      end
    end
  end
endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// tb_gelato_fetch_scheduler: directed stimulus checked against a rule-level model plus literal expectations
module tb_gelato_fetch_scheduler;
  localparam int N = 32;
  logic clk = 0, rst_n = 0;
  logic launch_valid = 0, wb_valid = 0, wb_exit = 0, caught = 0;
  logic [4:0] launch_warp = 0, wb_warp = 0;
  logic [31:0] launch_pc = 0, wb_pc = 0;
  logic [3:0] wb_split = 0;
  logic valid, all_idle;
  logic [31:0] pc;
  logic [4:0] warp_num;
  logic [3:0] split_table_num;
  int n_checks = 0, n_fail = 0;
  bit checking = 0;

  gelato_fetch_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_pc(launch_pc),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_pc(wb_pc), .wb_split(wb_split), .wb_exit(wb_exit),
    .valid(valid), .pc(pc), .warp_num(warp_num), .split_table_num(split_table_num),
    .caught(caught), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // rule-level model: warp tables plus the current offer
  bit m_act[N], m_rdy[N];
  logic [31:0] m_pcs[N];
  logic [3:0] m_spl[N];
  int m_rr, m_warp;
  bit m_valid;
  logic [31:0] m_pc;
  logic [3:0] m_split;

  function automatic int find_ready(input int from);
    for (int k = 0; k < N; k++) begin
      int w;
      w = (from + k) % N;
      if (m_act[w] && m_rdy[w]) return w;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    bit la, wa, choose;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_rdy[i] = 0; m_pcs[i] = 0; m_spl[i] = 0;
      end
      m_rr = 0; m_valid = 0; m_warp = 0; m_pc = 0; m_split = 0;
    end else begin
      la = launch_valid && !m_act[launch_warp];
      wa = wb_valid && m_act[wb_warp] && !m_rdy[wb_warp];
      choose = !m_valid || caught;
      if (m_valid && caught) begin
        m_rdy[m_warp] = 0;
        m_rr = (m_warp + 1) % N;
      end
      if (choose) begin
        w = find_ready(m_rr);
        m_valid = (w >= 0);
        if (w >= 0) begin
          m_warp = w; m_pc = m_pcs[w]; m_split = m_spl[w];
        end
      end
      if (la) begin
        m_act[launch_warp] = 1; m_rdy[launch_warp] = 1;
        m_pcs[launch_warp] = launch_pc; m_spl[launch_warp] = 0;
      end
      if (wa) begin
        m_act[wb_warp] = !wb_exit; m_rdy[wb_warp] = !wb_exit;
        if (!wb_exit) begin
          m_pcs[wb_warp] = wb_pc; m_spl[wb_warp] = wb_split;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit idle;
    if (checking) begin
      idle = 1;
      for (int i = 0; i < N; i++) if (m_act[i]) idle = 0;
      chk("model_valid", valid, m_valid);
      chk("model_all_idle", all_idle, idle);
      if (m_valid) begin
        chk("model_pc", pc, m_pc);
        chk("model_warp", warp_num, m_warp);
        chk("model_split", split_table_num, m_split);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic [4:0] w, input logic [31:0] p);
    launch_valid = 1; launch_warp = w; launch_pc = p;
    cyc();
    launch_valid = 0;
  endtask

  task automatic wb(input logic [4:0] w, input logic [31:0] p, input logic [3:0] s, input logic e);
    wb_valid = 1; wb_warp = w; wb_pc = p; wb_split = s; wb_exit = e;
    cyc();
    wb_valid = 0; wb_exit = 0;
  endtask

  task automatic catch_one();
    caught = 1;
    cyc();
    caught = 0;
  endtask

  initial begin
    cyc();
    checking = 1;
    cyc(2);
    chk("reset_valid", valid, 0);
    chk("reset_all_idle", all_idle, 1);
    chk("reset_pc", pc, 0);
    chk("reset_warp", warp_num, 0);
    chk("reset_split", split_table_num, 0);
    rst_n = 1;
    cyc();
    // single launch, held offer, then catch
    launch(3, 32'h1000);
    chk("launch_not_yet", valid, 0);
    cyc();
    chk("offer3_valid", valid, 1);
    chk("offer3_warp", warp_num, 3);
    chk("offer3_pc", pc, 32'h1000);
    chk("offer3_split", split_table_num, 0);
    chk("offer3_busy", all_idle, 0);
    cyc(5);
    chk("hold_warp", warp_num, 3);
    chk("hold_pc", pc, 32'h1000);
    catch_one();
    chk("caught3_valid", valid, 0);
    // writeback re-arms, exit retires
    wb(3, 32'h1004, 2, 0);
    cyc();
    chk("rearm_valid", valid, 1);
    chk("rearm_pc", pc, 32'h1004);
    chk("rearm_split", split_table_num, 2);
    catch_one();
    wb(3, 0, 0, 1);
    chk("exit_idle", all_idle, 1);
    cyc(4);
    chk("exit_no_offer", valid, 0);
    // back-to-back offers 0,1,2
    launch_valid = 1; launch_warp = 0; launch_pc = 32'h0;
    cyc();
    launch_warp = 1; launch_pc = 32'h100;
    cyc();
    chk("b2b_w0", warp_num, 0);
    chk("b2b_v0", valid, 1);
    launch_warp = 2; launch_pc = 32'h200;
    caught = 1;
    cyc();
    launch_valid = 0;
    chk("b2b_w1", warp_num, 1);
    chk("b2b_pc1", pc, 32'h100);
    cyc();
    chk("b2b_w2", warp_num, 2);
    chk("b2b_v2", valid, 1);
    cyc();
    caught = 0;
    chk("b2b_done", valid, 0);
    // protocol errors: wb to inactive, launch of active
    wb(9, 32'hdead, 5, 0);
    cyc(3);
    chk("wb_inactive_ignored", valid, 0);
    launch(0, 32'h7777);
    cyc(3);
    chk("launch_active_ignored", valid, 0);
    // rr from 3: warp 5 beats warp 0; wb to a ready warp ignored
    launch_valid = 1; launch_warp = 5; launch_pc = 32'h500;
    wb_valid = 1; wb_warp = 0; wb_pc = 32'h40; wb_split = 1;
    cyc();
    launch_valid = 0; wb_valid = 0;
    cyc();
    chk("rr_first_w5", warp_num, 5);
    wb(2, 32'h240, 3, 0);
    wb(0, 32'hbad0, 7, 0);
    wb(5, 32'hbad5, 7, 0);
    chk("held_pc5", pc, 32'h500);
    catch_one();
    chk("rr_wrap_w0", warp_num, 0);
    chk("ready_wb_ignored_pc", pc, 32'h40);
    chk("ready_wb_ignored_split", split_table_num, 1);
    catch_one();
    chk("next_w2", warp_num, 2);
    chk("next_split2", split_table_num, 3);
    catch_one();
    chk("all_caught", valid, 0);
    // rr_ptr=31 with warps 1 and 30 armed together
    wb(1, 0, 0, 1);
    launch(30, 32'h3000);
    cyc();
    chk("w30_offer", warp_num, 30);
    catch_one();
    launch_valid = 1; launch_warp = 1; launch_pc = 32'h5000;
    wb_valid = 1; wb_warp = 30; wb_pc = 32'h3004; wb_split = 1;
    cyc();
    launch_valid = 0; wb_valid = 0;
    chk("wrap_not_yet", valid, 0);
    cyc();
    chk("wrap_first_w1", warp_num, 1);
    chk("wrap_first_pc", pc, 32'h5000);
    catch_one();
    chk("wrap_second_w30", warp_num, 30);
    chk("wrap_second_pc", pc, 32'h3004);
    catch_one();
    chk("wrap_done", valid, 0);
    // reset while offering
    launch(6, 32'h600);
    cyc();
    chk("pre_reset_valid", valid, 1);
    rst_n = 0;
    cyc();
    chk("reset_mid_valid", valid, 0);
    chk("reset_mid_idle", all_idle, 1);
    rst_n = 1;
    cyc(3);
    chk("post_reset_quiet", valid, 0);
    launch(7, 32'h700);
    cyc();
    chk("post_reset_w7", warp_num, 7);
    chk("post_reset_pc7", pc, 32'h700);
    catch_one();
    cyc(2);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
